// File: rtl/alu_pkg.sv
// Shared definitions for the ALU op sequencer: widths, ALU control codes,
// command opcodes and the sequencer state type.
package alu_pkg;

  localparam int INTERNAL_BITS   = 16;
  localparam int DATA_W          = INTERNAL_BITS;
  localparam int ALUCONTROL_BITS = 4;

  localparam logic [ALUCONTROL_BITS-1:0] ALU_AND = 4'b0000;
  localparam logic [ALUCONTROL_BITS-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALUCONTROL_BITS-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALUCONTROL_BITS-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALUCONTROL_BITS-1:0] ALU_SLT = 4'b0111;
  localparam logic [ALUCONTROL_BITS-1:0] ALU_MUL = 4'b1000;
  localparam logic [ALUCONTROL_BITS-1:0] ALU_NOR = 4'b1100;

  localparam logic [2:0] OP_AND     = 3'd0;
  localparam logic [2:0] OP_OR      = 3'd1;
  localparam logic [2:0] OP_ADD     = 3'd2;
  localparam logic [2:0] OP_SUB     = 3'd3;
  localparam logic [2:0] OP_SLT     = 3'd4;
  localparam logic [2:0] OP_MUL     = 3'd5;
  localparam logic [2:0] OP_NOR     = 3'd6;
  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Maps a 3-bit command opcode onto the 4-bit ALU control code; unknown
// opcodes raise illegal and leave the code at zero.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [2:0]                 cmd_op,
  output logic [ALUCONTROL_BITS-1:0] alu_ctrl,
  output logic                       illegal
);

  always_comb begin
    alu_ctrl = '0;
    illegal  = 1'b0;
    case (cmd_op)
      OP_AND:  alu_ctrl = ALU_AND;
      OP_OR:   alu_ctrl = ALU_OR;
      OP_ADD:  alu_ctrl = ALU_ADD;
      OP_SUB:  alu_ctrl = ALU_SUB;
      OP_SLT:  alu_ctrl = ALU_SLT;
      OP_MUL:  alu_ctrl = ALU_MUL;
      OP_NOR:  alu_ctrl = ALU_NOR;
      default: illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Accepts one command at a time, drives it to an external ALU, waits for the
// result to settle (longer for MUL) and holds a response until consumed.
module alu_op_sequencer #(
  parameter int DATA_W   = alu_pkg::INTERNAL_BITS,
  parameter int MUL_WAIT = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                cmd_valid,
  output logic                                cmd_ready,
  input  logic [2:0]                          cmd_op,
  input  logic [DATA_W-1:0]                   cmd_a,
  input  logic [DATA_W-1:0]                   cmd_b,
  output logic [DATA_W-1:0]                   alu_src1,
  output logic [DATA_W-1:0]                   alu_src2,
  output logic [alu_pkg::ALUCONTROL_BITS-1:0] alu_ctrl,
  input  logic [DATA_W:0]                     alu_result,
  output logic                                rsp_valid,
  input  logic                                rsp_ready,
  output logic [DATA_W-1:0]                   rsp_result,
  output logic                                rsp_ovf,
  output logic                                rsp_zero,
  output logic                                rsp_err
);
  import alu_pkg::*;

  localparam int CNT_W = (MUL_WAIT > 1) ? $clog2(MUL_WAIT) : 1;

  state_t                     state;
  logic [CNT_W-1:0]           wait_cnt;
  logic [ALUCONTROL_BITS-1:0] dec_ctrl;
  logic                       dec_illegal;
  logic                       res_zero;

  alu_op_decode u_decode (
    .cmd_op   (cmd_op),
    .alu_ctrl (dec_ctrl),
    .illegal  (dec_illegal)
  );

  assign cmd_ready = (state == ST_IDLE);
  // Zero is derived here from the data bits so it never depends on the ALU's own flag.
  assign res_zero  = (alu_result[DATA_W-1:0] == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      alu_src1   <= '0;
      alu_src2   <= '0;
      alu_ctrl   <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_ovf    <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (dec_illegal) begin
              rsp_valid  <= 1'b1;
              rsp_err    <= 1'b1;
              rsp_result <= '0;
              rsp_ovf    <= 1'b0;
              rsp_zero   <= 1'b0;
              state      <= ST_RESP;
            end else begin
              alu_src1 <= cmd_a;
              alu_src2 <= cmd_b;
              alu_ctrl <= dec_ctrl;
              state    <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (alu_ctrl == ALU_MUL && MUL_WAIT > 0) begin
            wait_cnt <= '0;
            state    <= ST_WAIT;
          end else begin
            rsp_valid  <= 1'b1;
            rsp_result <= alu_result[DATA_W-1:0];
            rsp_ovf    <= alu_result[DATA_W];
            rsp_zero   <= res_zero;
            rsp_err    <= 1'b0;
            state      <= ST_RESP;
          end
        end
        ST_WAIT: begin
          if (int'(wait_cnt) >= MUL_WAIT - 1) begin
            rsp_valid  <= 1'b1;
            rsp_result <= alu_result[DATA_W-1:0];
            rsp_ovf    <= alu_result[DATA_W];
            rsp_zero   <= res_zero;
            rsp_err    <= 1'b0;
            state      <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU on the alu_* ports;
// expected values are hand-computed constants.
module tb_alu_op_sequencer;

  localparam int DW = 16;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [DW-1:0] cmd_a;
  logic [DW-1:0] cmd_b;
  logic [DW-1:0] alu_src1;
  logic [DW-1:0] alu_src2;
  logic [3:0]    alu_ctrl;
  logic [DW:0]   alu_result;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_result;
  logic          rsp_ovf;
  logic          rsp_zero;
  logic          rsp_err;
  logic [31:0]   prod;

  int compared   = 0;
  int mismatched = 0;

  alu_op_sequencer #(.DATA_W(DW), .MUL_WAIT(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .alu_src1   (alu_src1),
    .alu_src2   (alu_src2),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_ovf    (rsp_ovf),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: bit DW carries unsigned carry/borrow, or MUL high-half nonzero.
  always_comb begin
    prod       = alu_src1 * alu_src2;
    alu_result = '0;
    case (alu_ctrl)
      4'b0000: alu_result = {1'b0, alu_src1 & alu_src2};
      4'b0001: alu_result = {1'b0, alu_src1 | alu_src2};
      4'b0010: alu_result = {1'b0, alu_src1} + {1'b0, alu_src2};
      4'b0110: alu_result = {1'b0, alu_src1} - {1'b0, alu_src2};
      4'b0111: alu_result = {{DW{1'b0}}, ($signed(alu_src1) < $signed(alu_src2))};
      4'b1000: alu_result = {|prod[31:16], prod[15:0]};
      4'b1100: alu_result = {1'b0, ~(alu_src1 | alu_src2)};
      default: alu_result = '0;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] op,
                               input logic [DW-1:0] a, input logic [DW-1:0] b);
    cmd_valid = v;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Full non-MUL transaction with the two-cycle response latency checked.
  task automatic runOp(input string tag, input logic [2:0] op,
                       input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [3:0] exp_ctrl, input logic [DW-1:0] exp_res,
                       input logic exp_ovf, input logic exp_zero);
    applyStimulus(1'b1, op, a, b);
    checkOutput({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    step();
    applyStimulus(1'b0, 3'd0, '0, '0);
    checkOutput({tag, "_ctrl"}, 32'(alu_ctrl), 32'(exp_ctrl));
    checkOutput({tag, "_src1"}, 32'(alu_src1), 32'(a));
    checkOutput({tag, "_src2"}, 32'(alu_src2), 32'(b));
    checkOutput({tag, "_early_valid"}, 32'(rsp_valid), 32'd0);
    step();
    checkOutput({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    checkOutput({tag, "_result"}, 32'(rsp_result), 32'(exp_res));
    checkOutput({tag, "_ovf"}, 32'(rsp_ovf), 32'(exp_ovf));
    checkOutput({tag, "_zero"}, 32'(rsp_zero), 32'(exp_zero));
    checkOutput({tag, "_err"}, 32'(rsp_err), 32'd0);
    checkOutput({tag, "_busy"}, 32'(cmd_ready), 32'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checkOutput({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
    checkOutput({tag, "_done_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 3'd0, '0, '0);
    #12;
    checkOutput("rst_ctrl", 32'(alu_ctrl), 32'd0);
    checkOutput("rst_src1", 32'(alu_src1), 32'd0);
    checkOutput("rst_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_result", 32'(rsp_result), 32'd0);
    checkOutput("rst_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;
    step();
    checkOutput("rst_ready", 32'(cmd_ready), 32'd1);

    $display("[TB] basic operations");
    runOp("add", 3'd2, 16'h0003, 16'h0004, 4'b0010, 16'h0007, 1'b0, 1'b0);
    runOp("sub", 3'd3, 16'h1234, 16'h1234, 4'b0110, 16'h0000, 1'b0, 1'b1);
    runOp("and", 3'd0, 16'hF0F0, 16'h3C3C, 4'b0000, 16'h3030, 1'b0, 1'b0);
    runOp("or",  3'd1, 16'hF000, 16'h000F, 4'b0001, 16'hF00F, 1'b0, 1'b0);
    runOp("slt", 3'd4, 16'hFFFF, 16'h0001, 4'b0111, 16'h0001, 1'b0, 1'b0);
    runOp("nor", 3'd6, 16'h00FF, 16'h0F00, 4'b1100, 16'hF000, 1'b0, 1'b0);

    $display("[TB] multiply with settle cycles");
    applyStimulus(1'b1, 3'd5, 16'h0003, 16'h0005);
    step();
    applyStimulus(1'b0, 3'd0, '0, '0);
    checkOutput("mul_ctrl", 32'(alu_ctrl), 32'b1000);
    for (int i = 1; i <= 3; i++) begin
      checkOutput($sformatf("mul_n%0d_valid", i), 32'(rsp_valid), 32'd0);
      checkOutput($sformatf("mul_n%0d_ready", i), 32'(cmd_ready), 32'd0);
      step();
    end
    checkOutput("mul_valid", 32'(rsp_valid), 32'd1);
    checkOutput("mul_result", 32'(rsp_result), 32'h000F);
    checkOutput("mul_ready", 32'(cmd_ready), 32'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    $display("[TB] illegal opcode");
    applyStimulus(1'b1, 3'd7, 16'hAAAA, 16'h5555);
    step();
    applyStimulus(1'b0, 3'd0, '0, '0);
    checkOutput("ill_valid", 32'(rsp_valid), 32'd1);
    checkOutput("ill_err", 32'(rsp_err), 32'd1);
    checkOutput("ill_result", 32'(rsp_result), 32'd0);
    checkOutput("ill_zero", 32'(rsp_zero), 32'd0);
    checkOutput("ill_ctrl_held", 32'(alu_ctrl), 32'b1000);
    checkOutput("ill_src1_held", 32'(alu_src1), 32'h0003);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    $display("[TB] carry out with backpressure");
    applyStimulus(1'b1, 3'd2, 16'hFFFF, 16'h0001);
    step();
    applyStimulus(1'b0, 3'd0, '0, '0);
    step();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) applyStimulus(1'b1, 3'd0, 16'h1111, 16'h2222);
      else applyStimulus(1'b0, 3'd0, '0, '0);
      checkOutput($sformatf("bp%0d_valid", i), 32'(rsp_valid), 32'd1);
      checkOutput($sformatf("bp%0d_result", i), 32'(rsp_result), 32'h0000);
      checkOutput($sformatf("bp%0d_ovf", i), 32'(rsp_ovf), 32'd1);
      checkOutput($sformatf("bp%0d_zero", i), 32'(rsp_zero), 32'd1);
      checkOutput($sformatf("bp%0d_ready", i), 32'(cmd_ready), 32'd0);
      step();
    end
    applyStimulus(1'b0, 3'd0, '0, '0);
    checkOutput("bp_ctrl_held", 32'(alu_ctrl), 32'b0010);
    checkOutput("bp_src1_held", 32'(alu_src1), 32'hFFFF);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checkOutput("bp_idle", 32'(cmd_ready), 32'd1);

    $display("[TB] reset during multiply wait");
    applyStimulus(1'b1, 3'd5, 16'h0007, 16'h0009);
    step();
    applyStimulus(1'b0, 3'd0, '0, '0);
    step();
    rst_n = 1'b0;
    #1;
    checkOutput("mrst_ctrl", 32'(alu_ctrl), 32'd0);
    checkOutput("mrst_src1", 32'(alu_src1), 32'd0);
    checkOutput("mrst_src2", 32'(alu_src2), 32'd0);
    checkOutput("mrst_valid", 32'(rsp_valid), 32'd0);
    #2;
    rst_n = 1'b1;
    step();
    checkOutput("mrst_ready", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("mrst_quiet%0d", i), 32'(rsp_valid), 32'd0);
      step();
    end

    runOp("post", 3'd2, 16'h0100, 16'h0023, 4'b0010, 16'h0123, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
